mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-requester arbiter that shares a single valid/ready memory port between the processor's instruction-fetch port and its data port. It sits between the Processor's cache-side outputs and one unified, variable-latency memory model, so both the fetch and data paths can run against a single backing memory. The arbiter alternates fairly on contention, holds each grant until the memory completes, and aborts transactions that exceed a watchdog limit.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width on all ports
- DATA_WIDTH, 32, data width on all ports
- TIMEOUT, 64, max cycles waiting for mem_ready before abort; 0 disables the watchdog

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- instr_addr  in  ADDR_WIDTH  fetch address
- instr_valid  in  1  fetch request; held until instr_ready
- instr_rd  out  DATA_WIDTH  fetched word; valid while instr_ready=1
- instr_ready  out  1  one-cycle completion pulse to the fetch port
- data_addr  in  ADDR_WIDTH  data address
- data_wr  in  DATA_WIDTH  write data
- data_rw  in  1  1=write, 0=read
- data_valid  in  1  data request; held until data_ready
- data_rd  out  DATA_WIDTH  read word; valid while data_ready=1
- data_ready  out  1  one-cycle completion pulse to the data port
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wr_data  out  DATA_WIDTH  memory write data
- mem_rw  out  1  1=write
- mem_valid  out  1  memory request; held until mem_ready
- mem_rd_data  in  DATA_WIDTH  memory read data; valid with mem_ready
- mem_ready  in  1  memory completion pulse
- timeout_err  out  1  sticky watchdog flag

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If neither valid is high, stay in IDLE.
  - If exactly one valid is high, grant that port.
  - If both are high, grant the port not served last (`last_grant`).
  - On grant, register the granted addr, rw and wr data (instr grants force rw=0 and wr data=0), set owner and `last_grant`, then go to ISSUE.
- ISSUE:
  - mem_valid=1; mem_addr, mem_rw and mem_wr_data are driven from registers and stay stable.
  - On mem_ready: capture mem_rd_data into the owner's rd register (on writes, the rd register is not updated) and go to RESP.
  - Watchdog: a counter clears on entry to ISSUE and increments each cycle there. When it reaches TIMEOUT (TIMEOUT≠0) with no mem_ready: drop mem_valid, load rd with all-ones, set timeout_err, and go to RESP.
- RESP:
  - The owner's ready=1 for exactly one cycle, then go to IDLE.
  - Valid inputs are not sampled in RESP, because the served requester still holds valid during this cycle.
- mem_ready is ignored outside ISSUE; a late response after an abort is dropped.
- A requester that deasserts valid before its ready arrives is a protocol violation. The transaction still completes and the ready pulse still fires.
- rd outputs hold their last value between responses.
- timeout_err clears only on reset.

## Timing
- Reset values: state=IDLE, every output=0, owner=instr, last_grant=instr (so data wins the first tie), counter=0.
- Reset asserted mid-transaction returns the block to reset values immediately (asynchronously). The memory side sees mem_valid fall without mem_ready.
- Latency, with the request seen in IDLE at cycle 0:
  - mem_valid rises at cycle 1.
  - mem_ready arrives at cycle 1+N (N≥0 wait cycles).
  - The requester's ready pulse occurs at cycle 2+N.
- Throughput: one transaction per N+3 cycles. A waiting requester is granted on the IDLE cycle that follows RESP.
- Abort: mem_valid stays high for TIMEOUT cycles; the ready pulse follows in the next cycle.
- A mem_ready that arrives in the same cycle the counter hits TIMEOUT is treated as success; timeout_err is not set.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state enum (IDLE/ISSUE/RESP)
  - owner constants OWNER_INSTR=0 and OWNER_DATA=1
  - the abort fill constant, all-ones at DATA_WIDTH
- One sub-module is natural: `mem_arb_watchdog`, a counter with clear/enable, a TIMEOUT parameter and an expire output. Everything else lives in the top-level module.

## Test plan
- Single fetch, addr 0x10, memory latency 10, memory returns 0x1234_5678 → mem_valid at cycle 1, instr_ready one-cycle pulse at cycle 12 with instr_rd=0x1234_5678, data_ready stays 0.
- Data write addr 0x20, data 0xCAFE_F00D → mem_rw=1 and mem_wr_data=0xCAFE_F00D stable through ISSUE; data_ready pulse; a later read of 0x20 returns 0xCAFE_F00D.
- Both valid continuously for 4 transactions after reset → grant order data, instr, data, instr; no port is starved.
- TIMEOUT=8 with mem_ready never asserted → mem_valid high for exactly 8 cycles; requester ready pulse with rd=0xFFFF_FFFF; timeout_err=1 and stays 1 through further successful transactions.
- rst_n asserted during ISSUE → all outputs are 0 in the same cycle; after release, a new fetch completes normally and data wins the first tie.
- mem_ready pulsed while in IDLE → no ready pulse on either port and no state change.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {StIdle, StIssue, StResp} arbState_t;

  localparam logic OWNER_INSTR = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  localparam int unsigned ARB_DATA_WIDTH = 32;
  localparam logic [ARB_DATA_WIDTH-1:0] ABORT_FILL = '1;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Cycle counter for an outstanding memory request; flags expiry on the TIMEOUT-th cycle.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CntW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LastCnt)) begin
      count <= count + CntW'(1);
    end
  end

  // count == LastCnt means this is the TIMEOUT-th cycle of the request.
  assign expire = (TIMEOUT != 0) && enable && (count == LastCnt);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one valid/ready memory port between the fetch and data ports, alternating on
// contention and aborting requests the memory never answers.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = ARB_DATA_WIDTH,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_rd,
  output logic                  instr_ready,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wr,
  input  logic                  data_rw,
  input  logic                  data_valid,
  output logic [DATA_WIDTH-1:0] data_rd,
  output logic                  data_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_rw,
  output logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_ready,
  output logic                  timeout_err
);

  // Replicated so any DATA_WIDTH gets an all-ones abort word.
  localparam logic [DATA_WIDTH-1:0] AbortWord = {DATA_WIDTH{ABORT_FILL[0]}};

  arbState_t state;
  logic      owner;
  logic      lastGrant;
  logic      pickData;
  logic      wdExpire;

  assign pickData = data_valid && (!instr_valid || (lastGrant == OWNER_INSTR));

  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state != StIssue),
    .enable(state == StIssue),
    .expire(wdExpire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StIdle;
      owner       <= OWNER_INSTR;
      lastGrant   <= OWNER_INSTR;
      instr_rd    <= '0;
      instr_ready <= 1'b0;
      data_rd     <= '0;
      data_ready  <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_rw      <= 1'b0;
      mem_valid   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (instr_valid || data_valid) begin
            owner       <= pickData ? OWNER_DATA : OWNER_INSTR;
            lastGrant   <= pickData ? OWNER_DATA : OWNER_INSTR;
            mem_addr    <= pickData ? data_addr : instr_addr;
            mem_rw      <= pickData & data_rw;
            mem_wr_data <= pickData ? data_wr : '0;
            mem_valid   <= 1'b1;
            state       <= StIssue;
          end
        end
        StIssue: begin
          // A response in the expiry cycle still counts as success.
          if (mem_ready) begin
            if (!mem_rw) begin
              if (owner == OWNER_DATA) data_rd <= mem_rd_data;
              else                     instr_rd <= mem_rd_data;
            end
            mem_valid   <= 1'b0;
            instr_ready <= (owner == OWNER_INSTR);
            data_ready  <= (owner == OWNER_DATA);
            state       <= StResp;
          end else if (wdExpire) begin
            if (owner == OWNER_DATA) data_rd <= AbortWord;
            else                     instr_rd <= AbortWord;
            timeout_err <= 1'b1;
            mem_valid   <= 1'b0;
            instr_ready <= (owner == OWNER_INSTR);
            data_ready  <= (owner == OWNER_DATA);
            state       <= StResp;
          end
        end
        StResp: begin
          // Requester still holds valid here, so inputs are not sampled.
          instr_ready <= 1'b0;
          data_ready  <= 1'b0;
          state       <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
